// File: rtl/dbg_pkg.sv
// Shared types and constants for the debug halt controller: state encoding,
// dcsr.cause codes, drain counter width and the halt-cause priority helper.
package dbg_pkg;

  typedef logic [2:0] dbg_state_e;

  localparam dbg_state_e ST_RUN    = 3'd0;
  localparam dbg_state_e ST_DRAIN  = 3'd1;
  localparam dbg_state_e ST_HALTED = 3'd2;
  localparam dbg_state_e ST_RESUME = 3'd3;
  localparam dbg_state_e ST_STEP   = 3'd4;

  localparam logic [2:0] DBG_CAUSE_NONE    = 3'd0;
  localparam logic [2:0] DBG_CAUSE_EBREAK  = 3'd1;
  localparam logic [2:0] DBG_CAUSE_TRIGGER = 3'd2;
  localparam logic [2:0] DBG_CAUSE_HALTREQ = 3'd3;
  localparam logic [2:0] DBG_CAUSE_STEP    = 3'd4;

  localparam int DBG_CNT_W = 8;

  // ebreak beats trigger beats haltreq; dflt covers the no-event case
  function automatic logic [2:0] dbg_halt_cause(logic ebreak, logic trigger,
                                                logic haltreq, logic [2:0] dflt);
    if (ebreak)       return DBG_CAUSE_EBREAK;
    else if (trigger) return DBG_CAUSE_TRIGGER;
    else if (haltreq) return DBG_CAUSE_HALTREQ;
    else              return dflt;
  endfunction

endpackage

// File: rtl/debug_halt_controller.sv
// Core halt/resume/single-step sequencer for the external debug module.
// Define DBG_STEP_EN to enable single-step (dcsr_step / STEP state).
module debug_halt_controller
  import dbg_pkg::*;
#(
  parameter int DRAIN_MAX     = 15,
  parameter bit HALT_ON_RESET = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       haltreq,
  input  logic       resumereq,
  input  logic       ebreak_retire,
  input  logic       trigger_hit,
  input  logic       instr_retire,
  input  logic       mem_busy,
  input  logic       dcsr_step,
  output logic       core_running,
  output logic       core_halted,
  output logic       fetch_hold,
  output logic       dbg_ret,
  output logic       dpc_we,
  output logic [2:0] dcsr_cause,
  output logic       halted_ack,
  output logic       resume_ack,
  output logic       drain_err
);

  localparam dbg_state_e RST_STATE = HALT_ON_RESET ? ST_HALTED : ST_RUN;
  localparam logic [2:0] RST_CAUSE = HALT_ON_RESET ? DBG_CAUSE_HALTREQ : DBG_CAUSE_NONE;
  localparam logic [DBG_CNT_W-1:0] CNT_LAST = DBG_CNT_W'(DRAIN_MAX - 1);

  dbg_state_e           state_q, state_d;
  logic [DBG_CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]           cause_q, cause_d;
  logic                 err_q, err_d;
  logic                 dpc_we_q, dpc_we_d;
  logic                 step_go, retire, halt_evt;

`ifdef DBG_STEP_EN
  assign step_go = dcsr_step;
  assign retire  = instr_retire;
`else
  logic unused_step;
  assign unused_step = dcsr_step ^ instr_retire;
  assign step_go     = 1'b0;
  assign retire      = 1'b0;
`endif

  assign halt_evt = ebreak_retire | trigger_hit | haltreq;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    cause_d  = cause_q;
    err_d    = err_q;
    dpc_we_d = 1'b0;
    case (state_q)
      ST_RUN: if (halt_evt) begin
        state_d = ST_DRAIN;
        cnt_d   = '0;
        cause_d = dbg_halt_cause(ebreak_retire, trigger_hit, haltreq, DBG_CAUSE_HALTREQ);
      end
      ST_DRAIN: begin
        // a clean drain on the last allowed cycle is not a timeout
        if (!mem_busy) begin
          state_d  = ST_HALTED;
          dpc_we_d = 1'b1;
        end else if (cnt_q == CNT_LAST) begin
          state_d  = ST_HALTED;
          dpc_we_d = 1'b1;
          err_d    = 1'b1;
        end else begin
          cnt_d = cnt_q + DBG_CNT_W'(1);
        end
      end
      ST_HALTED: if (resumereq && !haltreq) begin
        state_d = ST_RESUME;
        err_d   = 1'b0;
      end
      ST_RESUME: state_d = step_go ? ST_STEP : ST_RUN;
      ST_STEP: if (halt_evt || retire) begin
        state_d = ST_DRAIN;
        cnt_d   = '0;
        cause_d = dbg_halt_cause(ebreak_retire, trigger_hit, haltreq, DBG_CAUSE_STEP);
      end
      default: state_d = RST_STATE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= RST_STATE;
      cnt_q    <= '0;
      cause_q  <= RST_CAUSE;
      err_q    <= 1'b0;
      dpc_we_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      cause_q  <= cause_d;
      err_q    <= err_d;
      dpc_we_q <= dpc_we_d;
    end
  end

  assign core_running = (state_q == ST_RUN) || (state_q == ST_DRAIN) || (state_q == ST_STEP);
  assign core_halted  = (state_q == ST_HALTED);
  assign halted_ack   = (state_q == ST_HALTED);
  assign fetch_hold   = (state_q == ST_DRAIN);
  assign dbg_ret      = (state_q == ST_RESUME);
  assign resume_ack   = (state_q == ST_RESUME);
  assign dpc_we       = dpc_we_q;
  assign dcsr_cause   = cause_q;
  assign drain_err    = err_q;

endmodule

// File: tb/tb_debug_halt_controller.sv
// Self-checking bench: directed vector table, hand sequences and random
// stimulus checked against a cycle-level behavioural model.
module tb_debug_halt_controller;

  localparam int DMAX = 4;
`ifdef DBG_STEP_EN
  localparam bit STEP_EN = 1'b1;
`else
  localparam bit STEP_EN = 1'b0;
`endif

  localparam int M_RUN = 0, M_DRAIN = 1, M_HALTED = 2, M_RESUME = 3, M_STEP = 4;

  logic clk = 1'b0;
  logic reset, haltreq, resumereq, ebreak_retire, trigger_hit, instr_retire, mem_busy, dcsr_step;
  logic core_running, core_halted, fetch_hold, dbg_ret, dpc_we, halted_ack, resume_ack, drain_err;
  logic [2:0] dcsr_cause;

  int n_cmp = 0;
  int n_bad = 0;

  int         m_mode;
  int         m_d;
  logic [2:0] m_cause;
  logic       m_err;
  logic       m_dpc;

  always #5 clk = ~clk;

  debug_halt_controller #(.DRAIN_MAX(DMAX), .HALT_ON_RESET(1'b0)) dut (
    .clk(clk), .reset(reset), .haltreq(haltreq), .resumereq(resumereq),
    .ebreak_retire(ebreak_retire), .trigger_hit(trigger_hit), .instr_retire(instr_retire),
    .mem_busy(mem_busy), .dcsr_step(dcsr_step), .core_running(core_running),
    .core_halted(core_halted), .fetch_hold(fetch_hold), .dbg_ret(dbg_ret), .dpc_we(dpc_we),
    .dcsr_cause(dcsr_cause), .halted_ack(halted_ack), .resume_ack(resume_ack),
    .drain_err(drain_err)
  );

  typedef struct {
    logic [7:0]  in;   // rst hreq rreq ebk trg ret busy stp
    logic [10:0] exp;  // run hlt hold dret dpc cause[2:0] hack rack err
  } vec_t;

  vec_t tbl[16];

  task automatic chk1(string nm, logic act, logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  task automatic chk3(string nm, logic [2:0] act, logic [2:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic model_step();
    logic       ev;
    logic [2:0] c;
    ev = haltreq | ebreak_retire | trigger_hit;
    c  = ebreak_retire ? 3'd1 : trigger_hit ? 3'd2 : haltreq ? 3'd3 : 3'd4;
    m_dpc = 1'b0;
    if (reset) begin
      m_mode = M_RUN; m_d = 0; m_cause = 3'd0; m_err = 1'b0;
    end else begin
      case (m_mode)
        M_RUN: if (ev) begin m_mode = M_DRAIN; m_d = 1; m_cause = c; end
        M_DRAIN: begin
          if (!mem_busy) begin m_mode = M_HALTED; m_dpc = 1'b1; end
          else if (m_d >= DMAX) begin m_mode = M_HALTED; m_dpc = 1'b1; m_err = 1'b1; end
          else m_d = m_d + 1;
        end
        M_HALTED: if (resumereq && !haltreq) begin m_mode = M_RESUME; m_err = 1'b0; end
        M_RESUME: m_mode = (STEP_EN && dcsr_step) ? M_STEP : M_RUN;
        default: if (ev || (STEP_EN && instr_retire)) begin
          m_mode = M_DRAIN; m_d = 1; m_cause = c;
        end
      endcase
    end
  endtask

  task automatic check_model();
    chk1("model_running", core_running, m_mode == M_RUN || m_mode == M_DRAIN || m_mode == M_STEP);
    chk1("model_halted",  core_halted,  m_mode == M_HALTED);
    chk1("model_hold",    fetch_hold,   m_mode == M_DRAIN);
    chk1("model_dbg_ret", dbg_ret,      m_mode == M_RESUME);
    chk1("model_rack",    resume_ack,   m_mode == M_RESUME);
    chk1("model_hack",    halted_ack,   m_mode == M_HALTED);
    chk1("model_dpc_we",  dpc_we,       m_dpc);
    chk3("model_cause",   dcsr_cause,   m_cause);
    chk1("model_err",     drain_err,    m_err);
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_model();
  endtask

  task automatic idle_inputs();
    {reset, haltreq, resumereq, ebreak_retire, trigger_hit, instr_retire, mem_busy, dcsr_step} = '0;
  endtask

  function automatic vec_t mk(logic [7:0] i, logic [10:0] e);
    vec_t v;
    v.in  = i;
    v.exp = e;
    return v;
  endfunction

  initial begin
    logic [2:0] cause_before;
    tbl[0]  = mk(8'b1000_0000, 11'b1_0_0_0_0_000_0_0_0);
    tbl[1]  = mk(8'b0100_0000, 11'b1_0_1_0_0_011_0_0_0);
    tbl[2]  = mk(8'b0000_0000, 11'b0_1_0_0_1_011_1_0_0);
    tbl[3]  = mk(8'b0000_0000, 11'b0_1_0_0_0_011_1_0_0);
    tbl[4]  = mk(8'b0010_0000, 11'b0_0_0_1_0_011_0_1_0);
    tbl[5]  = mk(8'b0000_0000, 11'b1_0_0_0_0_011_0_0_0);
    tbl[6]  = mk(8'b0101_0000, 11'b1_0_1_0_0_001_0_0_0);
    tbl[7]  = mk(8'b0100_0010, 11'b1_0_1_0_0_001_0_0_0);
    tbl[8]  = mk(8'b0100_0000, 11'b0_1_0_0_1_001_1_0_0);
    tbl[9]  = mk(8'b0110_0000, 11'b0_1_0_0_0_001_1_0_0);
    tbl[10] = mk(8'b0010_0000, 11'b0_0_0_1_0_001_0_1_0);
    tbl[11] = mk(8'b0100_1000, 11'b1_0_0_0_0_001_0_0_0);
    tbl[12] = mk(8'b0000_1000, 11'b1_0_1_0_0_010_0_0_0);
    tbl[13] = mk(8'b0010_0000, 11'b0_1_0_0_1_010_1_0_0);
    tbl[14] = mk(8'b0010_0000, 11'b0_0_0_1_0_010_0_1_0);
    tbl[15] = mk(8'b0000_0000, 11'b1_0_0_0_0_010_0_0_0);

    idle_inputs();
    for (int i = 0; i < 16; i++) begin
      {reset, haltreq, resumereq, ebreak_retire, trigger_hit, instr_retire, mem_busy, dcsr_step} = tbl[i].in;
      cycle();
      chk1($sformatf("tbl%0d_running", i), core_running, tbl[i].exp[10]);
      chk1($sformatf("tbl%0d_halted", i),  core_halted,  tbl[i].exp[9]);
      chk1($sformatf("tbl%0d_hold", i),    fetch_hold,   tbl[i].exp[8]);
      chk1($sformatf("tbl%0d_dbg_ret", i), dbg_ret,      tbl[i].exp[7]);
      chk1($sformatf("tbl%0d_dpc_we", i),  dpc_we,       tbl[i].exp[6]);
      chk3($sformatf("tbl%0d_cause", i),   dcsr_cause,   tbl[i].exp[5:3]);
      chk1($sformatf("tbl%0d_hack", i),    halted_ack,   tbl[i].exp[2]);
      chk1($sformatf("tbl%0d_rack", i),    resume_ack,   tbl[i].exp[1]);
      chk1($sformatf("tbl%0d_err", i),     drain_err,    tbl[i].exp[0]);
    end
    idle_inputs();

    // drain timeout: mem_busy never drops, forced halt after DMAX DRAIN cycles
    haltreq = 1'b1; mem_busy = 1'b1;
    cycle();
    haltreq = 1'b0;
    for (int k = 0; k < DMAX - 1; k++) begin
      cycle();
      chk1($sformatf("t4_draining%0d", k), fetch_hold, 1'b1);
    end
    cycle();
    chk1("t4_halted", halted_ack, 1'b1);
    chk1("t4_err_set", drain_err, 1'b1);
    chk1("t4_dpc_we", dpc_we, 1'b1);
    mem_busy = 1'b0;
    cycle();
    chk1("t4_err_sticky", drain_err, 1'b1);
    resumereq = 1'b1;
    cycle();
    resumereq = 1'b0;
    chk1("t4_err_clr", drain_err, 1'b0);
    chk1("t4_rack", resume_ack, 1'b1);
    cycle();
    chk1("t4_running", core_running, 1'b1);

    // single step: retire three cycles after resume
    haltreq = 1'b1;
    cycle();
    haltreq = 1'b0;
    cycle();
    cause_before = dcsr_cause;
    chk3("t5_cause_pre", cause_before, 3'd3);
    dcsr_step = 1'b1; resumereq = 1'b1;
    cycle();
    resumereq = 1'b0;
    cycle();
    chk1("t5_running", core_running, 1'b1);
    cycle();
    instr_retire = 1'b1;
    cycle();
    instr_retire = 1'b0;
    chk1("t5_drain", fetch_hold, STEP_EN);
    cycle();
    chk1("t5_halted", halted_ack, STEP_EN);
    chk3("t5_cause", dcsr_cause, STEP_EN ? 3'd4 : 3'd3);
    dcsr_step = 1'b0; resumereq = 1'b1;
    cycle();
    resumereq = 1'b0;
    cycle();

    // reset while draining with the bus busy
    haltreq = 1'b1; mem_busy = 1'b1;
    cycle();
    haltreq = 1'b0;
    cycle();
    chk1("t6_in_drain", fetch_hold, 1'b1);
    reset = 1'b1;
    cycle();
    reset = 1'b0; mem_busy = 1'b0;
    chk1("t6_running", core_running, 1'b1);
    chk1("t6_hold", fetch_hold, 1'b0);
    chk1("t6_err", drain_err, 1'b0);
    chk1("t6_hack", halted_ack, 1'b0);
    chk3("t6_cause", dcsr_cause, 3'd0);

    for (int n = 0; n < 3000; n++) begin
      reset         = ($urandom % 64) == 0;
      haltreq       = ($urandom % 8) == 0;
      resumereq     = ($urandom % 4) == 0;
      ebreak_retire = ($urandom % 16) == 0;
      trigger_hit   = ($urandom % 16) == 0;
      instr_retire  = ($urandom % 3) == 0;
      mem_busy      = ($urandom % 3) != 0;
      dcsr_step     = ($urandom % 2) == 0;
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
